// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcodes and FSM states for
// the SPI byte-level command decoder.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_CONF_WR   = 8'h2A;
  localparam logic [7:0] CMD_ADDR_WR   = 8'h2B;
  localparam logic [7:0] CMD_DATA_WR   = 8'h2C;
  localparam logic [7:0] CMD_STATUS_RD = 8'h3A;

  typedef enum logic [2:0] {
    IDLE,
    CONF,
    ADDR,
    DATA,
    STAT,
    DROP
  } state_t;

endpackage

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: opcode FSM fed by SPI byte strobes.
// Optional STATUS_RD via macro SPI_CMD_STATUS_RD_EN.
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int REG_N  = 4
) (
  input  logic                     clk_i,
  input  logic                     spi_rst_n,
  input  logic                     spi_byte_vld_i,
  input  logic [7:0]               spi_byte_data_i,
  input  logic [7:0]               status_i,
  output logic [7:0]               spi_byte_data_o,
  output logic                     reg_wr_en_o,
  output logic [$clog2(REG_N)-1:0] reg_wr_addr_o,
  output logic [7:0]               reg_wr_data_o,
  output logic                     ram_wr_en_o,
  output logic [RAM_AW-1:0]        ram_wr_addr_o,
  output logic [7:0]               ram_wr_data_o
);

  localparam int RW = $clog2(REG_N);

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  logic [RW-1:0]     idx_q, idx_d;
  logic              abyte_q, abyte_d;
  logic [7:0]        hi_q, hi_d;

  logic              reg_en_d;
  logic [RW-1:0]     reg_addr_d;
  logic [7:0]        reg_data_d;
  logic              ram_en_d;
  logic [RAM_AW-1:0] ram_addr_d;
  logic [7:0]        ram_data_d;

`ifdef SPI_CMD_STATUS_RD_EN
  logic [7:0] tx_q, tx_d;
  assign spi_byte_data_o = tx_q;
`else
  logic unused_status;
  assign unused_status   = ^status_i;
  assign spi_byte_data_o = 8'h00;
`endif

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    idx_d      = idx_q;
    abyte_d    = abyte_q;
    hi_d       = hi_q;
    reg_en_d   = 1'b0;
    reg_addr_d = reg_wr_addr_o;
    reg_data_d = reg_wr_data_o;
    ram_en_d   = 1'b0;
    ram_addr_d = ram_wr_addr_o;
    ram_data_d = ram_wr_data_o;
`ifdef SPI_CMD_STATUS_RD_EN
    tx_d       = tx_q;
`endif
    if (spi_byte_vld_i) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            (spi_byte_data_i == CMD_CONF_WR): begin
              state_d = CONF;
              idx_d   = '0;
            end
            (spi_byte_data_i == CMD_ADDR_WR): begin
              state_d = ADDR;
              abyte_d = 1'b0;
            end
            (spi_byte_data_i == CMD_DATA_WR): begin
              state_d = DATA;
            end
`ifdef SPI_CMD_STATUS_RD_EN
            (spi_byte_data_i == CMD_STATUS_RD): begin
              state_d = STAT;
              tx_d    = status_i;
            end
`endif
            default: begin
              state_d = DROP;
            end
          endcase
        end
        CONF: begin
          reg_en_d   = 1'b1;
          reg_addr_d = idx_q;
          reg_data_d = spi_byte_data_i;
          if (idx_q == RW'(REG_N - 1)) begin
            state_d = DROP;
          end else begin
            idx_d = idx_q + RW'(1);
          end
        end
        ADDR: begin
          if (!abyte_q) begin
            hi_d    = spi_byte_data_i;
            abyte_d = 1'b1;
          end else begin
            addr_d  = RAM_AW'({hi_q, spi_byte_data_i});
            abyte_d = 1'b0;
            state_d = IDLE;
          end
        end
        DATA: begin
          ram_en_d   = 1'b1;
          ram_addr_d = addr_q;
          ram_data_d = spi_byte_data_i;
          addr_d     = addr_q + RAM_AW'(1);
        end
        STAT: begin
        end
        DROP: begin
        end
        default: begin
          state_d = DROP;
        end
      endcase
    end
  end

  // State, counters and outputs; CS release clears all.
  always_ff @(posedge clk_i or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      idx_q         <= '0;
      abyte_q       <= 1'b0;
      hi_q          <= '0;
      reg_wr_en_o   <= 1'b0;
      reg_wr_addr_o <= '0;
      reg_wr_data_o <= '0;
      ram_wr_en_o   <= 1'b0;
      ram_wr_addr_o <= '0;
      ram_wr_data_o <= '0;
`ifdef SPI_CMD_STATUS_RD_EN
      tx_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      idx_q         <= idx_d;
      abyte_q       <= abyte_d;
      hi_q          <= hi_d;
      reg_wr_en_o   <= reg_en_d;
      reg_wr_addr_o <= reg_addr_d;
      reg_wr_data_o <= reg_data_d;
      ram_wr_en_o   <= ram_en_d;
      ram_wr_addr_o <= ram_addr_d;
      ram_wr_data_o <= ram_data_d;
`ifdef SPI_CMD_STATUS_RD_EN
      tx_q          <= tx_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder: directed frames with
// hand-computed strobes, addresses and data.
module tb_spi_cmd_decoder;

  logic       clk_i = 1'b0;
  logic       spi_rst_n;
  logic       vld;
  logic [7:0] din;
  logic [7:0] status;
  logic [7:0] tx;
  logic       reg_en;
  logic [1:0] reg_addr;
  logic [7:0] reg_data;
  logic       ram_en;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;

  int errs   = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  spi_cmd_decoder #(
    .RAM_AW(10),
    .REG_N (4)
  ) dut (
    .clk_i          (clk_i),
    .spi_rst_n      (spi_rst_n),
    .spi_byte_vld_i (vld),
    .spi_byte_data_i(din),
    .status_i       (status),
    .spi_byte_data_o(tx),
    .reg_wr_en_o    (reg_en),
    .reg_wr_addr_o  (reg_addr),
    .reg_wr_data_o  (reg_data),
    .ram_wr_en_o    (ram_en),
    .ram_wr_addr_o  (ram_addr),
    .ram_wr_data_o  (ram_data)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // One byte strobe; returns at the negedge after
  // the consuming posedge, where strobes are visible.
  task automatic xfer(input logic [7:0] b);
    @(negedge clk_i);
    vld = 1'b1;
    din = b;
    @(negedge clk_i);
    vld = 1'b0;
  endtask

  // Strobes must be single-cycle, then idle out the gap.
  task automatic gap(input string tag);
    @(negedge clk_i);
    check({tag, "_reg_off"}, reg_en, 1'b0);
    check({tag, "_ram_off"}, ram_en, 1'b0);
    repeat (14) @(negedge clk_i);
  endtask

  task automatic exp_reg(input string tag,
                         input logic [1:0] a,
                         input logic [7:0] d);
    check({tag, "_reg_en"}, reg_en, 1'b1);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    check({tag, "_reg_addr"}, reg_addr, a);
    check({tag, "_reg_data"}, reg_data, d);
    gap(tag);
  endtask

  task automatic exp_ram(input string tag,
                         input logic [9:0] a,
                         input logic [7:0] d);
    check({tag, "_ram_en"}, ram_en, 1'b1);
    check({tag, "_reg_en"}, reg_en, 1'b0);
    check({tag, "_ram_addr"}, ram_addr, a);
    check({tag, "_ram_data"}, ram_data, d);
    check({tag, "_tx"}, tx, 8'h00);
  endtask

  task automatic exp_none(input string tag);
    check({tag, "_reg_en"}, reg_en, 1'b0);
    check({tag, "_ram_en"}, ram_en, 1'b0);
    gap(tag);
  endtask

  task automatic new_frame();
    @(negedge clk_i);
    spi_rst_n = 1'b0;
    @(negedge clk_i);
    spi_rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    spi_rst_n = 1'b0;
    vld       = 1'b0;
    din       = 8'h00;
    status    = 8'h5C;
    repeat (3) @(negedge clk_i);
    check("rst_tx", tx, 8'h00);
    check("rst_reg_en", reg_en, 1'b0);
    check("rst_reg_addr", reg_addr, 2'd0);
    check("rst_reg_data", reg_data, 8'h00);
    check("rst_ram_en", ram_en, 1'b0);
    check("rst_ram_addr", ram_addr, 10'h000);
    check("rst_ram_data", ram_data, 8'h00);
    spi_rst_n = 1'b1;
    repeat (2) @(negedge clk_i);

    xfer(8'h2A); exp_none("conf_op");
    xfer(8'h05); exp_reg("conf0", 2'd0, 8'h05);
    xfer(8'h0A); exp_reg("conf1", 2'd1, 8'h0A);
    xfer(8'h06); exp_reg("conf2", 2'd2, 8'h06);
    xfer(8'h09); exp_reg("conf3", 2'd3, 8'h09);
    xfer(8'h77); exp_none("conf_extra");

    new_frame();
    xfer(8'h2B); exp_none("addr_op");
    xfer(8'h01); exp_none("addr_hi");
    xfer(8'h23); exp_none("addr_lo");
    xfer(8'h2C); exp_none("data_op");
    xfer(8'hAA); exp_ram("d123", 10'h123, 8'hAA);
    gap("d123");
    xfer(8'hBB); exp_ram("d124", 10'h124, 8'hBB);
    gap("d124");

    new_frame();
    xfer(8'h2B); exp_none("waddr_op");
    xfer(8'h03); exp_none("waddr_hi");
    xfer(8'hFF); exp_none("waddr_lo");
    xfer(8'h2C); exp_none("wdata_op");
    xfer(8'h11); exp_ram("d3ff", 10'h3FF, 8'h11);
    gap("d3ff");
    xfer(8'h22); exp_ram("dwrap", 10'h000, 8'h22);
    gap("dwrap");

    new_frame();
    status = 8'h5C;
    xfer(8'h3A);
`ifdef SPI_CMD_STATUS_RD_EN
    check("stat_tx", tx, 8'h5C);
`else
    check("stat_tx", tx, 8'h00);
`endif
    exp_none("stat_op");
    status = 8'h00;
    xfer(8'h55);
`ifdef SPI_CMD_STATUS_RD_EN
    check("stat_hold", tx, 8'h5C);
`else
    check("stat_hold", tx, 8'h00);
`endif
    exp_none("stat_extra");

    new_frame();
    check("frame_tx_clr", tx, 8'h00);
    xfer(8'h2C); exp_none("ab_op");
    xfer(8'h10); exp_ram("ab_d0", 10'h000, 8'h10);
    #1 spi_rst_n = 1'b0;
    #1 check("abort_async_clr", ram_en, 1'b0);
    @(negedge clk_i);
    spi_rst_n = 1'b1;
    repeat (2) @(negedge clk_i);
    xfer(8'h2C); exp_none("ab2_op");
    xfer(8'h20); exp_ram("ab2_d0", 10'h000, 8'h20);
    gap("ab2_d0");

    new_frame();
    xfer(8'h99); exp_none("unk_op");
    xfer(8'h12); exp_none("unk_d0");
    xfer(8'h2C); exp_none("unk_d1");
    xfer(8'h34); exp_none("unk_d2");

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
